iterative_multiplier: RTL and testbench
=======================================

Name: iterative_multiplier

Overview:
- Multi-cycle 64x64 shift-add multiplier for the LEGv8 MUL instruction.
- Consumes BusA/BusB straight from the register file outputs.
- Returns the product, destination register and a write strobe that feed the register file's BusW/RW/RegWr.
- Write strobe is launched off the rising edge, so the register file's falling-edge write captures it in the same cycle.

Parameters:
WIDTH, 64, operand/result width in bits; counter width is clog2(WIDTH).

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only in IDLE
BusA  input  WIDTH  multiplicand, sampled with Start
BusB  input  WIDTH  multiplier, sampled with Start
RWIn  input  5  destination register, sampled with Start
Busy  output  1  high in RUN and DONE
Done  output  1  one-cycle completion pulse
Result  output  WIDTH  low WIDTH bits of product
ResultHi  output  WIDTH  high WIDTH bits (see Optional Feature)
RWOut  output  5  latched destination register
RegWr  output  1  one-cycle write strobe to register file

Behaviour:
- Reset (sync, on the rising edge with Reset=1):
  - State goes to IDLE.
  - Busy, Done and RegWr go to 0.
  - Result, ResultHi and RWOut go to 0.
  - Counter and internal operands are cleared.
- Reset mid-operation aborts the multiply. No Done or RegWr is produced.
- States and transitions:
  - IDLE: when Start=1, latch BusA into the multiplicand (zero-extended to 2*WIDTH), BusB into the multiplier, and RWIn into RWOut. Clear the accumulator and counter. Go to RUN.
  - RUN, each edge:
    - If multiplier[0]=1, accumulator += multiplicand.
    - Shift multiplicand left 1, shift multiplier right 1, counter+1.
    - On the edge where counter==WIDTH-1 (the WIDTH-th iteration), load Result/ResultHi from the final accumulator and go to DONE.
  - DONE: Done=1 for exactly one cycle. RegWr=1 in the same cycle, unless RWOut==31, in which case RegWr stays 0 (XZR). Next edge goes to IDLE with Done=RegWr=0.
- Latency:
  - Start accepted at edge E.
  - Done/RegWr high in the cycle following edge E+WIDTH (E+64 by default).
  - Fixed regardless of operand values; no early termination.
- Start with Busy=1 is ignored. No queuing, and BusA/BusB/RWIn changes have no effect.
- Start in the DONE cycle is ignored. The earliest accept is the IDLE cycle that follows.
- Result/ResultHi/RWOut hold their values after DONE until the next accepted Start loads new values at the end of RUN. During RUN, Result keeps its previous value.
- Arithmetic:
  - Unsigned 2*WIDTH accumulation, modulo 2^(2*WIDTH).
  - The low half equals the two's-complement MUL result for signed operands as well.
- Reset and Start asserted together: Reset wins and the state is IDLE.

Optional Feature:
- Macro: MUL_HIGH_EN.
- Defined:
  - Full 2*WIDTH accumulator and multiplicand are implemented.
  - ResultHi = upper WIDTH bits of the unsigned product (UMULH).
- Undefined:
  - Accumulator and multiplicand are only WIDTH bits; bits shifted past WIDTH are discarded.
  - ResultHi is tied to 0.
  - Result, Done, RegWr and latency are unchanged.

Test Plan:
- Reset, then Start with BusA=3, BusB=5, RWIn=2 -> Busy=1 next cycle; Done=RegWr=1 exactly 64 edges later with Result=15, RWOut=2, ResultHi=0; Busy=0 the cycle after.
- BusA=64'hFFFF_FFFF_FFFF_FFFF, BusB=2 -> Result=64'hFFFF_FFFF_FFFF_FFFE; ResultHi=1 with MUL_HIGH_EN, 0 without.
- BusA=-7 (two's complement), BusB=6 -> Result=-42 (64'hFFFF_FFFF_FFFF_FFD6).
- Start at edge E with A=4, B=4; Start pulses at E+10 with A=9, B=9 -> single Done at E+64 with Result=16; no second Done follows.
- Start, then Reset at edge E+20 -> Busy=Done=RegWr=0 and Result=0; no Done at E+64; a fresh Start of 6x7 yields Result=42.
- RWIn=31 with A=2, B=3 -> Done=1 and Result=6 but RegWr stays 0; A=0, B=any -> Result=0 after full 64-cycle latency.

Source files
------------

// File: rtl/iterative_multiplier.sv
// iterative_multiplier: multi-cycle shift-add MUL for LEGv8; define MUL_HIGH_EN for a full-width accumulator and UMULH on ResultHi
module iterative_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [4:0]       RWIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [4:0]       RWOut,
  output logic             RegWr
);
  localparam int CW = $clog2(WIDTH);
`ifdef MUL_HIGH_EN
  localparam int MW = 2 * WIDTH;
`else
  localparam int MW = WIDTH;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [MW-1:0]    mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       rw_q, rw_d;
  logic             last;
  // next-state: latch operands in IDLE, one add-and-shift step per RUN edge
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    result_d = result_q;
    last     = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
    case (state_q)
      IDLE: if (Start) begin
        state_d  = RUN;
        mcand_d  = MW'(BusA);
        mplier_d = BusB;
        rw_d     = RWIn;
        acc_d    = '0;
        cnt_d    = '0;
      end
      RUN: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        result_d = last ? acc_d[WIDTH-1:0] : result_q;
        state_d  = last ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      rw_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      result_q <= result_d;
    end
  end
`ifdef MUL_HIGH_EN
  logic [WIDTH-1:0] result_hi_q;
  // upper product half, loaded alongside the low half on the final iteration
  always_ff @(posedge Clk) begin
    if (Reset) result_hi_q <= '0;
    else if (last) result_hi_q <= acc_d[MW-1:WIDTH];
  end
  assign ResultHi = result_hi_q;
`else
  assign ResultHi = '0;
`endif
  assign Busy   = state_q != IDLE;
  assign Done   = state_q == DONE;
  assign RegWr  = Done && (rw_q != 5'd31);
  assign Result = result_q;
  assign RWOut  = rw_q;
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: table, corner-sequence and random checks against a product model
module tb_iterative_multiplier;
  logic        Clk, Reset, Start;
  logic [63:0] BusA, BusB;
  logic [4:0]  RWIn;
  logic        Busy, Done, RegWr;
  logic [63:0] Result, ResultHi;
  logic [4:0]  RWOut;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] prev_result;

  iterative_multiplier #(.WIDTH(64)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BusA(BusA), .BusB(BusB), .RWIn(RWIn),
    .Busy(Busy), .Done(Done), .Result(Result), .ResultHi(ResultHi), .RWOut(RWOut), .RegWr(RegWr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rw;
    logic [63:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rw);
    @(negedge Clk);
    Start = 1'b1; BusA = a; BusB = b; RWIn = rw;
    @(posedge Clk);
    #1 Start = 1'b0;
    BusA = ~a; BusB = ~b; RWIn = ~rw;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge Clk);
      #1 lat++;
    end while (!Done && lat < 200);
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge Clk);
      #1 if (Done || RegWr) seen++;
    end
  endtask

  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rw,
                         input logic [63:0] exp_lo, input string tag);
    logic [127:0] full;
    logic [63:0]  exp_hi;
    int           lat;
    full = {64'd0, a} * {64'd0, b};
`ifdef MUL_HIGH_EN
    exp_hi = full[127:64];
`else
    exp_hi = 64'd0;
`endif
    start_op(a, b, rw);
    chk({tag, "_busy_run"}, 128'(Busy), 128'(1));
    chk({tag, "_hold_run"}, 128'(Result), 128'(prev_result));
    wait_done(lat);
    chk({tag, "_latency"}, 128'(lat), 128'(64));
    chk({tag, "_lo"}, 128'(Result), 128'(exp_lo));
    chk({tag, "_hi"}, 128'(ResultHi), 128'(exp_hi));
    chk({tag, "_rw"}, 128'(RWOut), 128'(rw));
    chk({tag, "_regwr"}, 128'(RegWr), 128'(rw != 5'd31));
    chk({tag, "_busy_done"}, 128'(Busy), 128'(1));
    @(posedge Clk);
    #1;
    chk({tag, "_done_clr"}, 128'({Done, RegWr, Busy}), 128'(0));
    chk({tag, "_lo_hold"}, 128'(Result), 128'(exp_lo));
    prev_result = exp_lo;
  endtask

  initial begin
    vec_t        vecs[6];
    int          lat, seen;
    logic [63:0] a, b;
    logic [127:0] full;
    vecs[0] = '{64'd3, 64'd5, 5'd2, 64'd15};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 5'd9, 64'hFFFF_FFFF_FFFF_FFD6};
    vecs[3] = '{64'd2, 64'd3, 5'd31, 64'd6};
    vecs[4] = '{64'd0, 64'hDEAD_BEEF_1234_5678, 5'd4, 64'd0};
    vecs[5] = '{64'h1_0000_0000, 64'h1_0000_0000, 5'd1, 64'd0};
    Reset = 1'b1; Start = 1'b0; BusA = '0; BusB = '0; RWIn = '0;
    prev_result = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    chk("reset_ctrl", 128'({Busy, Done, RegWr}), 128'(0));
    chk("reset_data", {Result, ResultHi}, 128'(0));
    chk("reset_rw", 128'(RWOut), 128'(0));

    foreach (vecs[i]) run_mul(vecs[i].a, vecs[i].b, vecs[i].rw, vecs[i].lo, $sformatf("vec%0d", i));

    // Start pulses while busy are ignored
    start_op(64'd4, 64'd4, 5'd3);
    repeat (9) @(posedge Clk);
    start_op(64'd9, 64'd9, 5'd5);
    wait_done(lat);
    chk("ign_latency", 128'(lat), 128'(54));
    chk("ign_lo", 128'(Result), 128'(16));
    chk("ign_rw", 128'(RWOut), 128'(3));
    // Start raised during the DONE cycle is ignored
    Start = 1'b1; BusA = 64'd5; BusB = 64'd5; RWIn = 5'd6;
    @(posedge Clk);
    #1 Start = 1'b0;
    chk("done_start_ign", 128'(Busy), 128'(0));
    count_done(100, seen);
    chk("ign_no_second_done", 128'(seen), 128'(0));
    chk("ign_lo_hold", 128'(Result), 128'(16));
    prev_result = 64'd16;

    // Reset mid-operation aborts
    start_op(64'd11, 64'd13, 5'd8);
    repeat (19) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    chk("abort_ctrl", 128'({Busy, Done, RegWr}), 128'(0));
    chk("abort_data", {Result, ResultHi}, 128'(0));
    chk("abort_rw", 128'(RWOut), 128'(0));
    count_done(60, seen);
    chk("abort_no_done", 128'(seen), 128'(0));
    prev_result = '0;
    run_mul(64'd6, 64'd7, 5'd12, 64'd42, "post_abort");

    // Reset and Start together: Reset wins
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b1; BusA = 64'd3; BusB = 64'd3;
    @(posedge Clk);
    #1 Reset = 1'b0; Start = 1'b0;
    chk("rst_start_busy", 128'(Busy), 128'(0));
    prev_result = '0;
    @(posedge Clk);
    #1 chk("rst_start_idle", 128'(Busy), 128'(0));

    // randomized operands against the arithmetic model
    for (int k = 0; k < 20; k++) begin
      a = {$urandom, $urandom};
      b = (k % 4 == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
      full = {64'd0, a} * {64'd0, b};
      run_mul(a, b, 5'($urandom_range(0, 31)), full[63:0], $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
